// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer: fetches 9-bit instructions, decodes them and steps each through
// FETCH/DECODE/EXEC/MEM/WB. The optional run-length counter is built when CTRL_CYCLE_COUNT_EN is defined.
module ctrl_sequencer #(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0,
  parameter int MEM_LAT    = 1
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Start,
  input  logic [8:0]      Instr,
  input  logic            Zero,
  output logic [PC_W-1:0] ProgCtr,
  output logic [1:0]      OP,
  output logic [1:0]      Function,
  output logic            RegWrEn,
  output logic            MemRdEn,
  output logic            MemWrEn,
  output logic            Ack,
  output logic [15:0]     CycleCount
);

  localparam logic [31:0]     START_W  = START_ADDR;
  localparam logic [PC_W-1:0] START_PC = START_W[PC_W-1:0];
  localparam logic [2:0]      WAIT_END = 3'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    K_ALU, K_BEQ, K_SW, K_LW, K_HALT, K_NOP
  } kind_t;

  function automatic kind_t decode(input logic [3:0] opf);
    case (opf)
      4'b0000, 4'b1000, 4'b1001, 4'b1100,
      4'b1101, 4'b0110, 4'b0111: return K_ALU;
      4'b0001:                   return K_BEQ;
      4'b0100:                   return K_SW;
      4'b0101:                   return K_LW;
      4'b0011:                   return K_HALT;
      default:                   return K_NOP;
    endcase
  endfunction

  state_t            state, state_next;
  logic [PC_W-1:0]   pc, pc_next, pc_inc, pc_branch;
  logic [8:0]        ir;
  logic [2:0]        wait_cnt, wait_next;
  kind_t             kind;
  logic signed [4:0]  br_imm;
  logic signed [31:0] br_ext;

  // Branch offset is sign-extended wide, then truncated so the add wraps modulo 2^PC_W.
  assign br_imm    = $signed(ir[4:0]);
  assign br_ext    = 32'(br_imm);
  assign pc_inc    = pc + PC_W'(1);
  assign pc_branch = pc + br_ext[PC_W-1:0];
  assign kind      = decode(ir[8:5]);

  assign ProgCtr  = pc;
  assign OP       = ir[8:7];
  assign Function = ir[6:5];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      pc       <= START_PC;
      ir       <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      wait_cnt <= wait_next;
      if (state == S_DECODE) ir <= Instr;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    wait_next  = wait_cnt;
    RegWrEn    = 1'b0;
    MemRdEn    = 1'b0;
    MemWrEn    = 1'b0;
    Ack        = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start) begin
          state_next = S_FETCH;
          pc_next    = START_PC;
        end
      end
      S_FETCH: state_next = S_DECODE;
      // ROM data is only valid now, so HALT is detected from Instr rather than IR.
      S_DECODE: state_next = (decode(Instr[8:5]) == K_HALT) ? S_DONE : S_EXEC;
      S_EXEC: begin
        case (kind)
          K_SW, K_LW: begin
            state_next = S_MEM;
            wait_next  = '0;
          end
          K_ALU: state_next = S_WB;
          default: begin
            state_next = S_FETCH;
            pc_next    = (kind == K_BEQ && Zero) ? pc_branch : pc_inc;
          end
        endcase
      end
      S_MEM: begin
        if (kind == K_SW) begin
          MemWrEn    = 1'b1;
          state_next = S_FETCH;
          pc_next    = pc_inc;
        end else begin
          MemRdEn = 1'b1;
          if (wait_cnt == WAIT_END) state_next = S_WB;
          else                      wait_next  = wait_cnt + 3'd1;
        end
      end
      S_WB: begin
        RegWrEn    = 1'b1;
        state_next = S_FETCH;
        pc_next    = pc_inc;
      end
      S_DONE: begin
        Ack = 1'b1;
        if (Start) begin
          state_next = S_FETCH;
          pc_next    = START_PC;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

`ifdef CTRL_CYCLE_COUNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] cycle_cnt;
  logic        start_accept;
  logic        counting;

  assign start_accept = Start && (state == S_IDLE || state == S_DONE);
  // DECODE of a HALT is the cycle that enters DONE, so it still counts.
  assign counting     = (state != S_IDLE) && (state != S_DONE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)          cycle_cnt <= '0;
    else if (start_accept) cycle_cnt <= '0;
    else if (counting)     cycle_cnt <= sat_inc(cycle_cnt);
  end

  assign CycleCount = cycle_cnt;
`else
  assign CycleCount = '0;
`endif

endmodule
